// File: rtl/alu_seq_ctrl_if.sv
// Button, handshake and strobe bundle between the ALU sequencer and the board datapath.
// The controller side uses the master modport; the datapath/board side uses slave.
`timescale 1ns/1ps
interface alu_seq_ctrl_if;
    logic       exe_btn;
    logic       back_btn;
    logic       alu_done;
    logic       ld_op1;
    logic       ld_op2;
    logic       ld_opc;
    logic       alu_start;
    logic       ld_result;
    logic       op1_src;
    logic       disp_clr;
    logic [1:0] disp_sel;
    logic       err;
    logic [2:0] c_state;

    modport master (
        input  exe_btn, back_btn, alu_done,
        output ld_op1, ld_op2, ld_opc, alu_start, ld_result,
               op1_src, disp_clr, disp_sel, err, c_state
    );

    modport slave (
        output exe_btn, back_btn, alu_done,
        input  ld_op1, ld_op2, ld_opc, alu_start, ld_result,
               op1_src, disp_clr, disp_sel, err, c_state
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Entry/launch/wait sequencer for the board ALU: drives load strobes, display select and clears.
// Optional macro CHAIN_RESULT_EN: EXE in the result state reloads operand 1 from the result register.
`timescale 1ns/1ps
module alu_seq_ctrl #(
    parameter int unsigned WAIT_MAX = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic           CLK100MHZ,
    input  logic           CPU_RESETN,
    input  logic           clr,
    alu_seq_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_OP1    = 3'd0,
        S_OP2    = 3'd1,
        S_OPC    = 3'd2,
        S_EXEC   = 3'd3,
        S_WAIT   = 3'd4,
        S_RESULT = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] next_cnt_s;
    logic             exe_q_r;
    logic             back_q_r;
    logic             exe_rise_s;
    logic             back_rise_s;
    logic [1:0]       disp_sel_r;
    logic             err_r;

    logic             ld_op1_s;
    logic             ld_op2_s;
    logic             ld_opc_s;
    logic             alu_start_s;
    logic             ld_result_s;
    logic             op1_src_s;
    logic             disp_clr_s;

    // Display source for a given state; the wait phase keeps the opcode visible.
    function automatic logic [1:0] disp_sel_of(input state_t s);
        case (s)
            S_OP1:    disp_sel_of = 2'd0;
            S_OP2:    disp_sel_of = 2'd1;
            S_OPC:    disp_sel_of = 2'd2;
            S_EXEC:   disp_sel_of = 2'd2;
            S_WAIT:   disp_sel_of = 2'd2;
            S_RESULT: disp_sel_of = 2'd3;
            S_ERR:    disp_sel_of = 2'd3;
            default:  disp_sel_of = 2'd0;
        endcase
    endfunction

    assign exe_rise_s  = bus.exe_btn  & ~exe_q_r;
    assign back_rise_s = bus.back_btn & ~back_q_r;

    // Button history; reset high so a button held through reset release is not an edge.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            exe_q_r  <= 1'b1;
            back_q_r <= 1'b1;
        end else begin
            exe_q_r  <= bus.exe_btn;
            back_q_r <= bus.back_btn;
        end
    end

    // State, wait counter and the state-derived display/error outputs.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_r    <= S_OP1;
            cnt_r      <= {CNT_W{1'b0}};
            disp_sel_r <= 2'd0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            cnt_r      <= next_cnt_s;
            disp_sel_r <= disp_sel_of(next_state_s);
            err_r      <= (next_state_s == S_ERR);
        end
    end

    // Next-state and Mealy strobe decode; clr overrides everything and suppresses strobes.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        ld_op1_s     = 1'b0;
        ld_op2_s     = 1'b0;
        ld_opc_s     = 1'b0;
        alu_start_s  = 1'b0;
        ld_result_s  = 1'b0;
        op1_src_s    = 1'b0;
        disp_clr_s   = 1'b0;
        if (clr) begin
            next_state_s = S_OP1;
            next_cnt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                S_OP1: begin
                    if (exe_rise_s) begin
                        ld_op1_s     = 1'b1;
                        disp_clr_s   = 1'b1;
                        next_state_s = S_OP2;
                    end else begin
                        next_state_s = S_OP1;
                    end
                end
                S_OP2: begin
                    if (exe_rise_s) begin
                        ld_op2_s     = 1'b1;
                        disp_clr_s   = 1'b1;
                        next_state_s = S_OPC;
                    end else if (back_rise_s) begin
                        disp_clr_s   = 1'b1;
                        next_state_s = S_OP1;
                    end else begin
                        next_state_s = S_OP2;
                    end
                end
                S_OPC: begin
                    if (exe_rise_s) begin
                        ld_opc_s     = 1'b1;
                        disp_clr_s   = 1'b1;
                        next_state_s = S_EXEC;
                    end else if (back_rise_s) begin
                        disp_clr_s   = 1'b1;
                        next_state_s = S_OP2;
                    end else begin
                        next_state_s = S_OPC;
                    end
                end
                S_EXEC: begin
                    alu_start_s  = 1'b1;
                    next_cnt_s   = {CNT_W{1'b0}};
                    next_state_s = S_WAIT;
                end
                S_WAIT: begin
                    // Done is checked first so a completion in the last allowed cycle still lands.
                    next_cnt_s = cnt_r + CNT_W'(1);
                    if (bus.alu_done) begin
                        ld_result_s  = 1'b1;
                        next_state_s = S_RESULT;
                    end else if (cnt_r == CNT_LAST) begin
                        next_state_s = S_ERR;
                    end else begin
                        next_state_s = S_WAIT;
                    end
                end
                S_RESULT: begin
                    if (exe_rise_s) begin
`ifdef CHAIN_RESULT_EN
                        ld_op1_s     = 1'b1;
                        op1_src_s    = 1'b1;
                        disp_clr_s   = 1'b1;
                        next_state_s = S_OP2;
`else
                        disp_clr_s   = 1'b1;
                        next_state_s = S_OP1;
`endif
                    end else begin
                        next_state_s = S_RESULT;
                    end
                end
                S_ERR: begin
                    if (exe_rise_s) begin
                        disp_clr_s   = 1'b1;
                        next_state_s = S_OP1;
                    end else begin
                        next_state_s = S_ERR;
                    end
                end
                default: begin
                    next_state_s = S_OP1;
                    next_cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.ld_op1    = ld_op1_s;
    assign bus.ld_op2    = ld_op2_s;
    assign bus.ld_opc    = ld_opc_s;
    assign bus.alu_start = alu_start_s;
    assign bus.ld_result = ld_result_s;
    assign bus.op1_src   = op1_src_s;
    assign bus.disp_clr  = disp_clr_s;
    assign bus.disp_sel  = disp_sel_r;
    assign bus.err       = err_r;
    assign bus.c_state   = state_r;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: stimulus queues expected strobe events, a negedge monitor checks them.
// Build with or without CHAIN_RESULT_EN; expectations follow the same macro.
`timescale 1ns/1ps
module tb_alu_seq_ctrl;

    typedef struct packed {
        logic [6:0] strb;
        logic [2:0] st;
        logic [1:0] dsel;
    } exp_t;

    // strobe vector order: {ld_op1, ld_op2, ld_opc, alu_start, ld_result, disp_clr, op1_src}
    localparam logic [6:0] V_OP1   = 7'b1000010;
    localparam logic [6:0] V_OP2   = 7'b0100010;
    localparam logic [6:0] V_OPC   = 7'b0010010;
    localparam logic [6:0] V_START = 7'b0001000;
    localparam logic [6:0] V_RES   = 7'b0000100;
    localparam logic [6:0] V_CLR   = 7'b0000010;
    localparam logic [6:0] V_CHAIN = 7'b1000011;

    logic clk;
    logic rst_n;
    logic clr;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];

    alu_seq_ctrl_if bus();

    alu_seq_ctrl #(.WAIT_MAX(16), .CNT_W(5)) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .clr        (clr),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic push(input logic [6:0] v, input logic [2:0] s, input logic [1:0] d);
        exp_t e;
        e.strb = v;
        e.st   = s;
        e.dsel = d;
        sb_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic e, input logic b);
        @(posedge clk);
        #1;
        bus.exe_btn  = e;
        bus.back_btn = b;
        @(posedge clk);
        #1;
        bus.exe_btn  = 1'b0;
        bus.back_btn = 1'b0;
    endtask

    task automatic do_clr();
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_state", 32'(bus.c_state), 32'd0);
    endtask

    task automatic to_exec();
        push(V_OP1, 3'd0, 2'd0);
        push(V_OP2, 3'd1, 2'd1);
        push(V_OPC, 3'd2, 2'd2);
        push(V_START, 3'd3, 2'd2);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
    endtask

    // Monitor: every cycle with any strobe high must match the next queued expectation.
    always @(negedge clk) begin
        logic [6:0] v;
        exp_t       e;
        v = {bus.ld_op1, bus.ld_op2, bus.ld_opc, bus.alu_start,
             bus.ld_result, bus.disp_clr, bus.op1_src};
        if (v != 7'd0) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: got %b in state %0d, none expected", v, bus.c_state);
            end else begin
                e = sb_q.pop_front();
                if (v !== e.strb || bus.c_state !== e.st || bus.disp_sel !== e.dsel) begin
                    n_fail++;
                    $display("FAIL strobe_event: got %b st %0d dsel %0d expected %b st %0d dsel %0d",
                             v, bus.c_state, bus.disp_sel, e.strb, e.st, e.dsel);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        clr          = 1'b0;
        bus.exe_btn  = 1'b1;
        bus.back_btn = 1'b0;
        bus.alu_done = 1'b0;
        #3;
        check("rst_state", 32'(bus.c_state), 32'd0);
        check("rst_dsel", 32'(bus.disp_sel), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_op1_src", 32'(bus.op1_src), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // exe held through reset release: no edge
        wait_cycles(5);
        check("held_exe_state", 32'(bus.c_state), 32'd0);
        bus.exe_btn = 1'b0;
        wait_cycles(1);
        push(V_OP1, 3'd0, 2'd0);
        press(1'b1, 1'b0);
        check("op1_to_op2", 32'(bus.c_state), 32'd1);
        check("op2_dsel", 32'(bus.disp_sel), 32'd1);

        // full pass, alu_done three cycles after alu_start
        push(V_OP2, 3'd1, 2'd1);
        push(V_OPC, 3'd2, 2'd2);
        push(V_START, 3'd3, 2'd2);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("exec_state", 32'(bus.c_state), 32'd3);
        wait_cycles(3);
        push(V_RES, 3'd4, 2'd2);
        bus.alu_done = 1'b1;
        wait_cycles(1);
        bus.alu_done = 1'b0;
        check("result_state", 32'(bus.c_state), 32'd5);
        check("result_dsel", 32'(bus.disp_sel), 32'd3);
        press(1'b0, 1'b1);
        check("result_back_ignored", 32'(bus.c_state), 32'd5);

        // exit from the result state
`ifdef CHAIN_RESULT_EN
        push(V_CHAIN, 3'd5, 2'd3);
        press(1'b1, 1'b0);
        check("result_exit_chain", 32'(bus.c_state), 32'd1);
`else
        push(V_CLR, 3'd5, 2'd3);
        press(1'b1, 1'b0);
        check("result_exit", 32'(bus.c_state), 32'd0);
`endif
        do_clr();

        // back navigation, then simultaneous edges in S_OP2
        push(V_OP1, 3'd0, 2'd0);
        push(V_OP2, 3'd1, 2'd1);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        push(V_CLR, 3'd2, 2'd2);
        press(1'b0, 1'b1);
        check("back_opc_to_op2", 32'(bus.c_state), 32'd1);
        push(V_CLR, 3'd1, 2'd1);
        press(1'b0, 1'b1);
        check("back_op2_to_op1", 32'(bus.c_state), 32'd0);
        press(1'b0, 1'b1);
        check("back_op1_ignored", 32'(bus.c_state), 32'd0);
        push(V_OP1, 3'd0, 2'd0);
        press(1'b1, 1'b0);
        push(V_OP2, 3'd1, 2'd1);
        press(1'b1, 1'b1);
        check("exe_beats_back", 32'(bus.c_state), 32'd2);

        // timeout: ERR exactly 16 cycles after leaving S_EXEC
        push(V_OPC, 3'd2, 2'd2);
        push(V_START, 3'd3, 2'd2);
        press(1'b1, 1'b0);
        wait_cycles(16);
        check("wait_before_timeout", 32'(bus.c_state), 32'd4);
        check("no_err_before_timeout", 32'(bus.err), 32'd0);
        wait_cycles(1);
        check("timeout_state", 32'(bus.c_state), 32'd6);
        check("timeout_err", 32'(bus.err), 32'd1);
        check("timeout_dsel", 32'(bus.disp_sel), 32'd3);
        press(1'b0, 1'b1);
        check("err_back_ignored", 32'(bus.c_state), 32'd6);
        push(V_CLR, 3'd6, 2'd3);
        press(1'b1, 1'b0);
        check("err_exit_state", 32'(bus.c_state), 32'd0);
        check("err_exit_err", 32'(bus.err), 32'd0);

        // alu_done in the timeout cycle wins
        to_exec();
        wait_cycles(16);
        push(V_RES, 3'd4, 2'd2);
        bus.alu_done = 1'b1;
        wait_cycles(1);
        bus.alu_done = 1'b0;
        check("done_at_limit_state", 32'(bus.c_state), 32'd5);
        check("done_at_limit_err", 32'(bus.err), 32'd0);
        do_clr();

        // alu_done outside S_WAIT is ignored
        bus.alu_done = 1'b1;
        wait_cycles(1);
        bus.alu_done = 1'b0;
        check("stray_done_state", 32'(bus.c_state), 32'd0);

        // clr in S_WAIT together with alu_done: no ld_result
        to_exec();
        wait_cycles(3);
        clr          = 1'b1;
        bus.alu_done = 1'b1;
        wait_cycles(1);
        clr          = 1'b0;
        bus.alu_done = 1'b0;
        check("clr_in_wait", 32'(bus.c_state), 32'd0);
        wait_cycles(2);
        check("clr_in_wait_hold", 32'(bus.c_state), 32'd0);

        // async reset between clock edges in S_OPC
        push(V_OP1, 3'd0, 2'd0);
        push(V_OP2, 3'd1, 2'd1);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("pre_async_state", 32'(bus.c_state), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(bus.c_state), 32'd0);
        check("async_rst_dsel", 32'(bus.disp_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(2);
        check("post_async_state", 32'(bus.c_state), 32'd0);

        wait_cycles(3);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
